music_beat_player: RTL
======================

// Module: music_beat_player
// PURPOSE
//  Sequencer and tone synthesiser for the song ROMs (Music1..3 style: ibeatNum[7:0] -> tone[31:0] Hz).
//  Drives the beat index into a combinational song ROM at a fixed quarter-beat rate and reads back the tone.
//  Turns each tone into a square-wave PCM sample stream for the audio DAC path.
//  Sits between the player control FSM (play/stop/loop) and the audio serializer.
// PARAMETERS
//  CLK_FREQ     100_000_000  system clock frequency, Hz
//  BEAT_FREQ    8            quarter-beat steps per second
//  LAST_BEAT    231          final beat index of the song; must be <= 255
//  SILENCE_THR  20000        tone >= this value is a rest (silence)
//  VOLUME       16'sh1FFF    square-wave amplitude, positive value
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-high
//  play         in   1   level: 1 = run, 0 = pause (hold position)
//  stop         in   1   pulse: return to beat 0 and go idle
//  loop_en      in   1   1 = wrap to beat 0 after LAST_BEAT; 0 = finish
//  tone         in   32  tone frequency (Hz) from the song ROM for beat_num
//  beat_num     out  8   beat index to the song ROM
//  audio_sample out  16  signed PCM: +VOLUME, -VOLUME or 0
//  playing      out  1   1 while in PLAY
//  song_done    out  1   one-cycle pulse when LAST_BEAT completes (looping or not)
// BEHAVIOUR
//  Reset values: beat_num=0, audio_sample=0, playing=0, song_done=0; state IDLE; timer, accumulator, square=0.
//  FSM: IDLE --play=1--> PLAY; PLAY --play=0--> PAUSE; PAUSE --play=1--> PLAY.
//   PLAY --end of LAST_BEAT, loop_en=0--> DONE; DONE --play=0--> IDLE (no retrigger while play held).
//   stop=1 in any state -> IDLE next cycle; beat_num=0, timer=0, accumulator=0, square=0. stop wins over play.
//  Beat timer: counts 0..CLK_FREQ/BEAT_FREQ-1 in PLAY only; frozen in PAUSE; cleared in IDLE/DONE.
//   At terminal count: beat_num increments; at LAST_BEAT it wraps to 0 (loop_en=1) or stays (DONE entry).
//   song_done pulses in that same terminal cycle. loop_en is sampled in that cycle only.
//  Tone capture: tone_q <= tone one cycle after each beat_num update (the ROM is combinational).
//   Entering PLAY from IDLE also captures tone_q. Tone changes mid-beat are ignored.
//  Synthesis uses a phase accumulator, with no divider. acc is 33-bit unsigned.
//   Each PLAY cycle: acc += 2*tone_q. If the result >= CLK_FREQ: subtract CLK_FREQ and toggle square.
//   The output frequency equals tone_q Hz. tone_q==0 holds square.
//  On a tone_q change, acc and square are NOT reset (phase-continuous).
//  Rest: tone_q >= SILENCE_THR -> audio_sample=0 and acc cleared to 0.
//  audio_sample is registered: PLAY and not a rest -> square ? VOLUME : -VOLUME; otherwise 0.
//   Latency is 1 cycle from square.
//  PAUSE holds acc/square/beat_num and outputs 0. Resume continues exactly where it paused.
//  Shifted tones (tone<<2 up to ~2 kHz) must fit: 2*tone_q < CLK_FREQ is required and not checked.
//  Async rst mid-song: all state returns to reset values immediately; no song_done pulse.
// TESTING (bench params CLK_FREQ=1000, BEAT_FREQ=10 -> 100 cycles/beat, LAST_BEAT=3)
//  1 rst, then play=1 with tone=100 -> square toggles every 5 cycles.
//    audio_sample alternates +/-16'sh1FFF with period 10; beat_num steps 0,1,2,3 every 100 cycles.
//  2 loop_en=1 -> after beat 3, beat_num=0 and song_done pulses once per 400 cycles.
//    loop_en=0 -> beat_num stays 3, playing=0, DONE until play drops.
//  3 tone=20000 on beat 1 -> audio_sample=0 for that full beat; tone=250 on the next beat -> toggles every 2 cycles.
//  4 play=0 at cycle 150 for 50 cycles -> outputs 0, beat_num frozen.
//    Resume: beat 1 ends at cycle 250, not 200.
//  5 stop pulse mid-beat 2 (also with play=1 held) -> next cycle beat_num=0, playing=0, audio_sample=0.
//    Play restarts from beat 0.
//  6 async rst asserted mid-beat, between clock edges -> all outputs 0 before the next edge; song_done stays 0.

Source files
------------

// File: rtl/music_beat_player.sv
// music_beat_player
//   Song sequencer and square-wave tone synthesiser. Steps a beat index
//   through a combinational song ROM at a fixed quarter-beat rate. Each tone
//   (Hz) is turned into a signed square-wave PCM stream by a phase
//   accumulator.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   play         level: 1 = run, 0 = pause (hold position)
//   stop         pulse: return to beat 0 and go idle (wins over play)
//   loop_en      1 = wrap to beat 0 after LAST_BEAT, 0 = finish
//   tone         tone (Hz) from the song ROM for beat_num
//   beat_num     beat index to the song ROM
//   audio_sample signed PCM: +VOLUME, -VOLUME or 0
//   playing      1 while in PLAY
//   song_done    one-cycle pulse when LAST_BEAT completes
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | stopped; timer/accumulator/square held at 0
// S_PLAY  | beat timer and phase accumulator running, audio driven
// S_PAUSE | everything frozen, audio 0
// S_DONE  | song finished without looping; waits for play to drop
module music_beat_player #(
  parameter int unsigned       CLK_FREQ    = 100_000_000,
  parameter int unsigned       BEAT_FREQ   = 8,
  parameter int unsigned       LAST_BEAT   = 231,
  parameter int unsigned       SILENCE_THR = 20000,
  parameter logic signed [15:0] VOLUME     = 16'sh1FFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               play,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [31:0]        tone,
  output logic [7:0]         beat_num,
  output logic signed [15:0] audio_sample,
  output logic               playing,
  output logic               song_done
);

  localparam int unsigned BEAT_TICKS = CLK_FREQ / BEAT_FREQ;
  localparam int          TW         = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
  localparam logic [TW-1:0] TIMER_TC = TW'(BEAT_TICKS - 1);
  localparam logic [32:0] ACC_WRAP   = 33'(CLK_FREQ);
  localparam logic [7:0]  LAST       = 8'(LAST_BEAT);
  localparam logic [31:0] THR        = 32'(SILENCE_THR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [7:0]         beat_q, beat_d;
  logic [31:0]        tone_q, tone_d;
  logic               cap_q, cap_d;
  logic [32:0]        acc_q, acc_d;
  logic               square_q, square_d;
  logic signed [15:0] audio_q, audio_d;
  logic               playing_q, playing_d;
  logic               done_q, done_d;

  logic               is_rest;
  logic               terminal;
  logic [32:0]        acc_sum;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    beat_d    = beat_q;
    tone_d    = tone_q;
    cap_d     = 1'b0;
    acc_d     = acc_q;
    square_d  = square_q;
    audio_d   = '0;
    done_d    = 1'b0;

    is_rest  = (tone_q >= THR);
    terminal = (timer_q == TIMER_TC);
    // Adding 2*tone per clock and wrapping at CLK_FREQ toggles the square
    // 2*tone times a second, i.e. a full period at tone Hz.
    acc_sum  = acc_q + {tone_q, 1'b0};

    // The ROM is combinational; take the tone one cycle after beat_num moved.
    if (cap_q) begin
      tone_d = tone;
    end

    if (stop) begin
      state_d  = S_IDLE;
      timer_d  = '0;
      beat_d   = '0;
      acc_d    = '0;
      square_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          timer_d  = '0;
          acc_d    = '0;
          square_d = 1'b0;
          if (play) begin
            state_d = S_PLAY;
            tone_d  = tone;
          end
        end
        S_PLAY: begin
          if (is_rest) begin
            acc_d = '0;
          end else begin
            audio_d = square_q ? VOLUME : -VOLUME;
            if (acc_sum >= ACC_WRAP) begin
              acc_d    = acc_sum - ACC_WRAP;
              square_d = ~square_q;
            end else begin
              acc_d = acc_sum;
            end
          end

          if (terminal) begin
            timer_d = '0;
            if (beat_q == LAST) begin
              done_d = 1'b1;
              if (loop_en) begin
                beat_d = '0;
                cap_d  = 1'b1;
              end else begin
                state_d = S_DONE;
              end
            end else begin
              beat_d = beat_q + 8'd1;
              cap_d  = 1'b1;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end

          if (state_d == S_PLAY && !play) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (play) begin
            state_d = S_PLAY;
          end
        end
        S_DONE: begin
          timer_d = '0;
          // Holding play must not restart the song.
          if (!play) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    playing_d = (state_d == S_PLAY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      beat_q    <= '0;
      tone_q    <= '0;
      cap_q     <= 1'b0;
      acc_q     <= '0;
      square_q  <= 1'b0;
      audio_q   <= '0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      beat_q    <= beat_d;
      tone_q    <= tone_d;
      cap_q     <= cap_d;
      acc_q     <= acc_d;
      square_q  <= square_d;
      audio_q   <= audio_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign beat_num     = beat_q;
  assign audio_sample = audio_q;
  assign playing      = playing_q;
  assign song_done    = done_q;

endmodule
